// File: rtl/bitstream_cfi_flash_writer_pkg.sv
// Shared constants for the CFI flash writer: AMD command bytes, unlock
// addresses, FSM state encoding and the command-step lookup helpers.
package bitstream_cfi_flash_writer_pkg;

  localparam logic [7:0]  CMD_UNLOCK1     = 8'hAA;
  localparam logic [7:0]  CMD_UNLOCK2     = 8'h55;
  localparam logic [7:0]  CMD_PROGRAM     = 8'hA0;
  localparam logic [7:0]  CMD_ERASE_SETUP = 8'h80;
  localparam logic [7:0]  CMD_CHIP_ERASE  = 8'h10;
  localparam logic [21:0] ADDR_UNLOCK1    = 22'h555;
  localparam logic [21:0] ADDR_UNLOCK2    = 22'h2AA;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PROG_CMD,
    ST_ERASE_CMD,
    ST_POLL,
    ST_ERROR
  } state_t;

  // Data byte for command step 'step'; program uses steps 0..3, erase 0..5.
  function automatic logic [7:0] cmd_data(input logic erase, input logic [2:0] step,
                                          input logic [7:0] data_byte);
    case (step)
      3'd0:    cmd_data = CMD_UNLOCK1;
      3'd1:    cmd_data = CMD_UNLOCK2;
      3'd2:    cmd_data = erase ? CMD_ERASE_SETUP : CMD_PROGRAM;
      3'd3:    cmd_data = erase ? CMD_UNLOCK1 : data_byte;
      3'd4:    cmd_data = CMD_UNLOCK2;
      3'd5:    cmd_data = CMD_CHIP_ERASE;
      default: cmd_data = 8'h00;
    endcase
  endfunction

  // Bus address for command step 'step'; the program data lands at prog_addr.
  function automatic logic [21:0] cmd_addr(input logic erase, input logic [2:0] step,
                                           input logic [21:0] prog_addr);
    case (step)
      3'd0:    cmd_addr = ADDR_UNLOCK1;
      3'd1:    cmd_addr = ADDR_UNLOCK2;
      3'd2:    cmd_addr = ADDR_UNLOCK1;
      3'd3:    cmd_addr = erase ? ADDR_UNLOCK1 : prog_addr;
      3'd4:    cmd_addr = ADDR_UNLOCK2;
      3'd5:    cmd_addr = ADDR_UNLOCK1;
      default: cmd_addr = 22'h0;
    endcase
  endfunction

endpackage

// File: rtl/bitstream_cfi_flash_writer_bus_cycle.sv
// One flash bus transaction (write or poll read) with registered strobes.
// A start accepted in the final clock of a cycle chains the next cycle
// without a dead clock, so command writes run back to back.
module cfi_bus_cycle #(
  parameter int WritePeriod = 3,
  parameter int ReadPeriod  = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        rd,
  input  logic [21:0] addr,
  input  logic [7:0]  wdata,
  input  logic [7:0]  flash_data_in,
  output logic [21:0] flash_addr,
  output logic [7:0]  flash_data_out,
  output logic        flash_data_oe,
  output logic        flash_ce_n,
  output logic        flash_oe_n,
  output logic        flash_we_n,
  output logic [7:0]  rd_data,
  output logic        done
);

  localparam logic [7:0] WrLast    = 8'(WritePeriod + 2);
  localparam logic [7:0] WrDrvLast = 8'(WritePeriod + 1);
  localparam logic [7:0] WeLast    = 8'(WritePeriod);
  localparam logic [7:0] RdLast    = 8'(ReadPeriod + 1);
  localparam logic [7:0] RdStrLast = 8'(ReadPeriod);

  logic       active, rd_q, launch;
  logic [7:0] cnt;
  logic       nxt_active, nxt_rd;
  logic [7:0] nxt_cnt;
  logic       ce_d, oe_d, we_d, doe_d;

  assign done   = active && (rd_q ? (cnt == RdLast) : (cnt == WrLast));
  assign launch = start && (!active || done);

  // Next phase of the cycle and the strobe levels that phase requires.
  always_comb begin
    nxt_active = active;
    nxt_cnt    = cnt;
    nxt_rd     = rd_q;
    ce_d       = 1'b1;
    oe_d       = 1'b1;
    we_d       = 1'b1;
    doe_d      = 1'b0;
    if (launch) begin
      nxt_active = 1'b1;
      nxt_cnt    = 8'd0;
      nxt_rd     = rd;
    end else if (done) begin
      nxt_active = 1'b0;
    end else if (active) begin
      nxt_cnt = cnt + 8'd1;
    end
    if (nxt_active) begin
      if (nxt_rd) begin
        if (nxt_cnt <= RdStrLast) begin
          ce_d = 1'b0;
          oe_d = 1'b0;
        end
      end else begin
        if (nxt_cnt <= WrDrvLast) begin
          ce_d  = 1'b0;
          doe_d = 1'b1;
        end
        if (nxt_cnt >= 8'd1 && nxt_cnt <= WeLast) we_d = 1'b0;
      end
    end
  end

  // Phase counter, registered strobes, bus latches and read sampling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active         <= 1'b0;
      rd_q           <= 1'b0;
      cnt            <= 8'd0;
      flash_ce_n     <= 1'b1;
      flash_oe_n     <= 1'b1;
      flash_we_n     <= 1'b1;
      flash_data_oe  <= 1'b0;
      flash_addr     <= 22'h0;
      flash_data_out <= 8'h00;
      rd_data        <= 8'h00;
    end else begin
      active        <= nxt_active;
      rd_q          <= nxt_rd;
      cnt           <= nxt_cnt;
      flash_ce_n    <= ce_d;
      flash_oe_n    <= oe_d;
      flash_we_n    <= we_d;
      flash_data_oe <= doe_d;
      if (launch) begin
        flash_addr <= addr;
        if (!rd) flash_data_out <= wdata;
      end
      if (active && rd_q && cnt == RdStrLast) rd_data <= flash_data_in;
    end
  end

endmodule

// File: rtl/bitstream_cfi_flash_writer.sv
// Programs a byte stream into AMD-command-set CFI NOR flash at sequential
// addresses, with optional chip erase; completion is detected by DQ7 polling.
module bitstream_cfi_flash_writer
  import bitstream_cfi_flash_writer_pkg::*;
#(
  parameter int WritePeriod  = 3,
  parameter int ReadPeriod   = 3,
  parameter int TimeoutPolls = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        erase_req,
  input  logic        wr_valid,
  input  logic [7:0]  wr_data,
  output logic        wr_ready,
  output logic        busy,
  output logic        error,
  output logic        mem_full,
  output logic [21:0] prog_addr,
  output logic [21:0] flash_addr,
  input  logic [7:0]  flash_data_in,
  output logic [7:0]  flash_data_out,
  output logic        flash_data_oe,
  output logic        flash_ce_n,
  output logic        flash_oe_n,
  output logic        flash_we_n,
  output logic        flash_rst_n
);

  localparam logic [15:0] PollLimit = 16'(TimeoutPolls);
  localparam logic [21:0] AddrLast  = 22'h3FFFFF;

  state_t      state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [7:0]  data_q, data_d;
  logic [21:0] prog_addr_q, prog_addr_d;
  logic        mem_full_q, mem_full_d;
  logic [15:0] poll_cnt_q, poll_cnt_d;
  logic        dq5_q, dq5_d;
  logic        erase_q, erase_d;

  logic        bus_start, bus_rd, bus_done;
  logic [21:0] bus_addr;
  logic [7:0]  bus_wdata, bus_rd_data;
  logic        handshake, poll_match;
  logic [2:0]  step_next, step_final;
  logic        unused_rd_bits;

  assign error       = (state_q == ST_ERROR);
  assign busy        = (state_q == ST_PROG_CMD) || (state_q == ST_ERASE_CMD) || (state_q == ST_POLL);
  assign wr_ready    = (state_q == ST_IDLE) && !mem_full_q && !error && !erase_req;
  assign handshake   = wr_valid && wr_ready;
  assign mem_full    = mem_full_q;
  assign prog_addr   = prog_addr_q;
  assign flash_rst_n = rst_n;
  assign step_next   = step_q + 3'd1;
  assign step_final  = erase_q ? 3'd5 : 3'd3;
  assign poll_match  = erase_q ? bus_rd_data[7] : (bus_rd_data[7] == data_q[7]);
  assign unused_rd_bits = ^{bus_rd_data[6], bus_rd_data[4:0]};

  cfi_bus_cycle #(
    .WritePeriod(WritePeriod),
    .ReadPeriod (ReadPeriod)
  ) u_bus (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (bus_start),
    .rd            (bus_rd),
    .addr          (bus_addr),
    .wdata         (bus_wdata),
    .flash_data_in (flash_data_in),
    .flash_addr    (flash_addr),
    .flash_data_out(flash_data_out),
    .flash_data_oe (flash_data_oe),
    .flash_ce_n    (flash_ce_n),
    .flash_oe_n    (flash_oe_n),
    .flash_we_n    (flash_we_n),
    .rd_data       (bus_rd_data),
    .done          (bus_done)
  );

  // Sequencer: issues command writes from the step counter, then polls DQ7.
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    data_d      = data_q;
    prog_addr_d = prog_addr_q;
    mem_full_d  = mem_full_q;
    poll_cnt_d  = poll_cnt_q;
    dq5_d       = dq5_q;
    erase_d     = erase_q;
    bus_start   = 1'b0;
    bus_rd      = 1'b0;
    bus_addr    = 22'h0;
    bus_wdata   = 8'h00;
    case (state_q)
      ST_IDLE: begin
        if (erase_req || handshake) begin
          state_d   = erase_req ? ST_ERASE_CMD : ST_PROG_CMD;
          erase_d   = erase_req;
          if (!erase_req) data_d = wr_data;
          step_d    = 3'd0;
          bus_start = 1'b1;
          bus_addr  = ADDR_UNLOCK1;
          bus_wdata = CMD_UNLOCK1;
        end
      end
      ST_PROG_CMD, ST_ERASE_CMD: begin
        if (bus_done) begin
          bus_start = 1'b1;
          if (step_q == step_final) begin
            state_d    = ST_POLL;
            poll_cnt_d = 16'd0;
            dq5_d      = 1'b0;
            bus_rd     = 1'b1;
            bus_addr   = erase_q ? 22'h0 : prog_addr_q;
          end else begin
            step_d    = step_next;
            bus_addr  = cmd_addr(erase_q, step_next, prog_addr_q);
            bus_wdata = cmd_data(erase_q, step_next, data_q);
          end
        end
      end
      ST_POLL: begin
        if (bus_done) begin
          poll_cnt_d = poll_cnt_q + 16'd1;
          if (poll_match) begin
            state_d = ST_IDLE;
            if (erase_q) begin
              prog_addr_d = 22'h0;
              mem_full_d  = 1'b0;
            end else begin
              prog_addr_d = prog_addr_q + 22'd1;
              if (prog_addr_q == AddrLast) mem_full_d = 1'b1;
            end
          end else if (dq5_q || (poll_cnt_d == PollLimit)) begin
            state_d = ST_ERROR;
          end else begin
            dq5_d     = bus_rd_data[5];
            bus_start = 1'b1;
            bus_rd    = 1'b1;
            bus_addr  = erase_q ? 22'h0 : prog_addr_q;
          end
        end
      end
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any flash operation at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      step_q      <= 3'd0;
      data_q      <= 8'h00;
      prog_addr_q <= 22'h0;
      mem_full_q  <= 1'b0;
      poll_cnt_q  <= 16'd0;
      dq5_q       <= 1'b0;
      erase_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      data_q      <= data_d;
      prog_addr_q <= prog_addr_d;
      mem_full_q  <= mem_full_d;
      poll_cnt_q  <= poll_cnt_d;
      dq5_q       <= dq5_d;
      erase_q     <= erase_d;
    end
  end

endmodule
